// File: rtl/nexys_starship_monster_array.sv
// Monster lane array for the starship game: a global INIT/PLAY/OVER FSM and per-lane spawn/kill timers.
// Optional score counter is enabled with the NEXYS_STARSHIP_SCORE_EN macro.
module nexys_starship_monster_array #(
    parameter int NUM_LANES      = 4,
    parameter int TIMER_W        = 8,
    parameter int SPAWN_DELAY    = 2,
    parameter int GAMEOVER_LIMIT = 10,
    localparam int CNT_W         = $clog2(NUM_LANES + 1)
) (
    input  logic                 timer_clk,
    input  logic                 Reset,
    input  logic                 play,
    input  logic                 restart,
    input  logic [NUM_LANES-1:0] kill,
    input  logic [NUM_LANES-1:0] rand_bits,
    output logic [NUM_LANES-1:0] monster,
    output logic                 gameover,
    output logic [CNT_W-1:0]     active_cnt,
`ifdef NEXYS_STARSHIP_SCORE_EN
    output logic [15:0]          score,
`endif
    output logic [2:0]           q_state
);

    typedef enum logic [2:0] {
        S_INIT = 3'b001,
        S_PLAY = 3'b010,
        S_OVER = 3'b100
    } state_t;

    localparam logic [TIMER_W-1:0] SPAWN_D  = TIMER_W'(SPAWN_DELAY);
    localparam logic [TIMER_W-1:0] LIMIT_M1 = TIMER_W'(GAMEOVER_LIMIT - 1);
    localparam logic [TIMER_W-1:0] ONE      = TIMER_W'(1);

    state_t               state_q, state_d;
    logic [NUM_LANES-1:0] full_q, full_d;
    logic [TIMER_W-1:0]   age_q   [NUM_LANES];
    logic [TIMER_W-1:0]   age_d   [NUM_LANES];
    logic [TIMER_W-1:0]   delay_q [NUM_LANES];
    logic [TIMER_W-1:0]   delay_d [NUM_LANES];
    logic                 hit;
    logic [CNT_W-1:0]     active_d;
    logic [CNT_W-1:0]     kill_cnt;
`ifdef NEXYS_STARSHIP_SCORE_EN
    logic [15:0]          score_d;
    logic [16:0]          score_sum;
`endif

    always_comb begin
        full_d   = full_q;
        hit      = 1'b0;
        kill_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            age_d[i]   = age_q[i];
            delay_d[i] = delay_q[i];
        end

        if (state_q == S_PLAY) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (full_q[i]) begin
                    // A kill on the tick the limit would be reached takes priority over game over.
                    if (kill[i]) begin
                        full_d[i]  = 1'b0;
                        age_d[i]   = '0;
                        delay_d[i] = '0;
                        kill_cnt   = kill_cnt + CNT_W'(1);
                    end else begin
                        age_d[i] = age_q[i] + ONE;
                        if (age_q[i] == LIMIT_M1)
                            hit = 1'b1;
                    end
                end else if (delay_q[i] == SPAWN_D && rand_bits[i]) begin
                    full_d[i]  = 1'b1;
                    age_d[i]   = '0;
                    delay_d[i] = '0;
                end else if (delay_q[i] != SPAWN_D) begin
                    delay_d[i] = delay_q[i] + ONE;
                end
            end
        end

        state_d = state_q;
        case (state_q)
            S_INIT:  if (play)    state_d = S_PLAY;
            S_PLAY:  if (hit)     state_d = S_OVER;
            S_OVER:  if (restart) state_d = S_INIT;
            default:              state_d = S_INIT;
        endcase

`ifdef NEXYS_STARSHIP_SCORE_EN
        score_sum = {1'b0, score} + 17'(kill_cnt);
        score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif

        // Lanes are cleared on the tick INIT is entered so outputs already read empty there.
        if (state_d == S_INIT) begin
            full_d = '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                age_d[i]   = '0;
                delay_d[i] = '0;
            end
`ifdef NEXYS_STARSHIP_SCORE_EN
            score_d = '0;
`endif
        end

        active_d = '0;
        for (int i = 0; i < NUM_LANES; i++)
            active_d = active_d + CNT_W'(full_d[i]);
    end

    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_INIT;
            full_q     <= '0;
            active_cnt <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                age_q[i]   <= '0;
                delay_q[i] <= '0;
            end
`ifdef NEXYS_STARSHIP_SCORE_EN
            score      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            active_cnt <= active_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                age_q[i]   <= age_d[i];
                delay_q[i] <= delay_d[i];
            end
`ifdef NEXYS_STARSHIP_SCORE_EN
            score      <= score_d;
`endif
        end
    end

    assign monster  = full_q;
    assign gameover = (state_q == S_OVER);
    assign q_state  = state_q;

endmodule

// File: tb/tb_nexys_starship_monster_array.sv
// Bench for nexys_starship_monster_array: directed scenarios plus random play against a lane-level model.
module tb_nexys_starship_monster_array;
    localparam int NL = 4;
    localparam int SD = 2;
    localparam int GL = 10;

    logic          timer_clk;
    logic          Reset;
    logic          play;
    logic          restart;
    logic [NL-1:0] kill;
    logic [NL-1:0] rand_bits;
    logic [NL-1:0] monster;
    logic          gameover;
    logic [2:0]    active_cnt;
    logic [2:0]    q_state;
`ifdef NEXYS_STARSHIP_SCORE_EN
    logic [15:0]   score;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: 0=INIT, 1=PLAY, 2=OVER
    int m_state;
    int m_full [NL];
    int m_age  [NL];
    int m_dly  [NL];
    int m_score;

    nexys_starship_monster_array dut (
        .timer_clk (timer_clk),
        .Reset     (Reset),
        .play      (play),
        .restart   (restart),
        .kill      (kill),
        .rand_bits (rand_bits),
        .monster   (monster),
        .gameover  (gameover),
        .active_cnt(active_cnt),
`ifdef NEXYS_STARSHIP_SCORE_EN
        .score     (score),
`endif
        .q_state   (q_state)
    );

    initial begin
        timer_clk = 1'b0;
        forever #5 timer_clk = ~timer_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    function automatic void model_clear();
        for (int i = 0; i < NL; i++) begin
            m_full[i] = 0;
            m_age[i]  = 0;
            m_dly[i]  = 0;
        end
        m_score = 0;
    endfunction

    function automatic void model_step(input logic p, input logic r,
                                       input logic [NL-1:0] k, input logic [NL-1:0] rb);
        int over;
        over = 0;
        if (m_state == 0) begin
            if (p) m_state = 1;
        end else if (m_state == 1) begin
            for (int i = 0; i < NL; i++) begin
                if (m_full[i] != 0) begin
                    if (k[i]) begin
                        m_full[i] = 0; m_age[i] = 0; m_dly[i] = 0;
                        m_score++;
                    end else begin
                        m_age[i]++;
                        if (m_age[i] == GL) over = 1;
                    end
                end else if (m_dly[i] == SD && rb[i]) begin
                    m_full[i] = 1; m_age[i] = 0; m_dly[i] = 0;
                end else if (m_dly[i] < SD) begin
                    m_dly[i]++;
                end
            end
            if (m_score > 65535) m_score = 65535;
            if (over != 0) m_state = 2;
        end else begin
            if (r) begin
                m_state = 0;
                model_clear();
            end
        end
    endfunction

    function automatic logic [NL-1:0] model_monster();
        logic [NL-1:0] v;
        v = '0;
        for (int i = 0; i < NL; i++) v[i] = (m_full[i] != 0);
        return v;
    endfunction

    function automatic int model_count();
        int c;
        c = 0;
        for (int i = 0; i < NL; i++) c += m_full[i];
        return c;
    endfunction

    task automatic tick();
        @(posedge timer_clk);
        model_step(play, restart, kill, rand_bits);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; play = 1'b0; restart = 1'b0; kill = '0; rand_bits = '0;
        @(negedge timer_clk);
        @(negedge timer_clk);
        Reset = 1'b0;
        m_state = 0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (monster !== 4'b0000 || gameover !== 1'b0 || active_cnt !== 3'd0 || q_state !== 3'b001) begin
            errors++;
            $display("FAIL reset_state: monster=%b gameover=%b active_cnt=%0d q_state=%b, want 0000 0 0 001",
                     monster, gameover, active_cnt, q_state);
        end
    endtask

    task automatic test_spawn();
        play = 1'b1; rand_bits = 4'b0001;
        tick();
        checks++;
        if (q_state !== 3'b010) begin
            errors++; $display("FAIL play_entry: q_state=%b want 010", q_state);
        end
        tick(); tick();
        checks++;
        if (monster !== 4'b0000) begin
            errors++; $display("FAIL spawn_early: monster=%b want 0000 after 2 ticks", monster);
        end
        tick();
        checks++;
        if (monster !== 4'b0001 || active_cnt !== 3'd1) begin
            errors++; $display("FAIL spawn_third_tick: monster=%b active_cnt=%0d want 0001 1", monster, active_cnt);
        end
        play = 1'b0; rand_bits = '0;
    endtask

    task automatic test_gameover();
        for (int t = 1; t <= 9; t++) begin
            tick();
            checks++;
            if (gameover !== 1'b0 || q_state !== 3'b010) begin
                errors++; $display("FAIL gameover_early: tick %0d gameover=%b q_state=%b want 0 010", t, gameover, q_state);
            end
        end
        tick();
        checks++;
        if (gameover !== 1'b1 || q_state !== 3'b100 || monster !== 4'b0001) begin
            errors++; $display("FAIL gameover_limit: gameover=%b q_state=%b monster=%b want 1 100 0001",
                               gameover, q_state, monster);
        end
        play = 1'b1; kill = 4'b1111; rand_bits = 4'b1111;
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if (monster !== 4'b0001 || q_state !== 3'b100 || active_cnt !== 3'd1) begin
                errors++; $display("FAIL over_frozen: monster=%b q_state=%b active_cnt=%0d want 0001 100 1",
                                   monster, q_state, active_cnt);
            end
        end
        play = 1'b0; kill = '0; rand_bits = '0; restart = 1'b1;
        tick();
        checks++;
        if (q_state !== 3'b001 || monster !== 4'b0000 || gameover !== 1'b0 || active_cnt !== 3'd0) begin
            errors++; $display("FAIL restart_init: q_state=%b monster=%b gameover=%b active_cnt=%0d want 001 0000 0 0",
                               q_state, monster, gameover, active_cnt);
        end
        restart = 1'b0;
    endtask

    task automatic test_kill_race();
        do_reset();
        play = 1'b1; rand_bits = 4'b0001;
        repeat (4) tick();
        play = 1'b0; rand_bits = '0;
        repeat (9) tick();
        kill = 4'b0001;
        tick();
        kill = '0;
        checks++;
        if (monster !== 4'b0000 || gameover !== 1'b0 || q_state !== 3'b010) begin
            errors++; $display("FAIL kill_wins: monster=%b gameover=%b q_state=%b want 0000 0 010",
                               monster, gameover, q_state);
        end
`ifdef NEXYS_STARSHIP_SCORE_EN
        checks++;
        if (score !== 16'd1) begin
            errors++; $display("FAIL kill_score: score=%0d want 1", score);
        end
`endif
    endtask

    task automatic test_multi_kill();
        do_reset();
        play = 1'b1; rand_bits = 4'b1111;
        repeat (4) tick();
        play = 1'b0; rand_bits = '0;
        checks++;
        if (monster !== 4'b1111 || active_cnt !== 3'd4) begin
            errors++; $display("FAIL all_spawn: monster=%b active_cnt=%0d want 1111 4", monster, active_cnt);
        end
        kill = 4'b1111;
        tick();
        kill = '0;
        checks++;
        if (monster !== 4'b0000 || active_cnt !== 3'd0) begin
            errors++; $display("FAIL all_kill: monster=%b active_cnt=%0d want 0000 0", monster, active_cnt);
        end
`ifdef NEXYS_STARSHIP_SCORE_EN
        checks++;
        if (score !== 16'd4) begin
            errors++; $display("FAIL multi_score: score=%0d want 4", score);
        end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        play = 1'b1; rand_bits = 4'b0011;
        repeat (4) tick();
        play = 1'b0; rand_bits = '0;
        checks++;
        if (monster !== 4'b0011) begin
            errors++; $display("FAIL two_lanes: monster=%b want 0011", monster);
        end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if (monster !== 4'b0000 || active_cnt !== 3'd0 || gameover !== 1'b0 || q_state !== 3'b001) begin
            errors++; $display("FAIL async_reset: monster=%b active_cnt=%0d gameover=%b q_state=%b want 0000 0 0 001",
                               monster, active_cnt, gameover, q_state);
        end
        #3 Reset = 1'b0;
        m_state = 0;
        model_clear();
        rand_bits = 4'b1111;
        for (int t = 0; t < 20; t++) begin
            tick();
            checks++;
            if (monster !== 4'b0000 || q_state !== 3'b001) begin
                errors++; $display("FAIL no_spawn_after_reset: tick %0d monster=%b q_state=%b want 0000 001",
                                   t, monster, q_state);
            end
        end
        rand_bits = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 600; t++) begin
            play      = ($urandom_range(0, 3) == 0);
            restart   = ($urandom_range(0, 7) == 0);
            rand_bits = NL'($urandom_range(0, 15));
            for (int i = 0; i < NL; i++) kill[i] = ($urandom_range(0, 5) == 0);
            tick();
            checks++;
            if (monster !== model_monster() || active_cnt !== 3'(model_count())
                || q_state !== 3'(1 << m_state) || gameover !== (m_state == 2)) begin
                errors++;
                $display("FAIL random_tick %0d: monster=%b cnt=%0d q_state=%b gameover=%b want %b %0d %b %0d",
                         t, monster, active_cnt, q_state, gameover, model_monster(), model_count(),
                         3'(1 << m_state), (m_state == 2));
            end
`ifdef NEXYS_STARSHIP_SCORE_EN
            checks++;
            if (score !== 16'(m_score)) begin
                errors++; $display("FAIL random_score %0d: score=%0d want %0d", t, score, m_score);
            end
`endif
        end
        play = 1'b0; restart = 1'b0; kill = '0; rand_bits = '0;
    endtask

    initial begin
        Reset = 1'b1; play = 1'b0; restart = 1'b0; kill = '0; rand_bits = '0;
        m_state = 0;
        model_clear();
        test_reset();
        test_spawn();
        test_gameover();
        test_kill_race();
        test_multi_kill();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nexys_starship_monster_array.md
NEXYS_STARSHIP_MONSTER_ARRAY -- requirements
Module: nexys_starship_monster_array

Interface
REQ-001 Parameter NUM_LANES, default 4, number of independent monster lanes (1..8).
REQ-002 Parameter TIMER_W, default 8, width of each lane's age and delay counters.
REQ-003 Parameter SPAWN_DELAY, default 2, minimum timer_clk ticks a lane stays empty before it may spawn; 1..2^TIMER_W-1.
REQ-004 Parameter GAMEOVER_LIMIT, default 10, age in ticks at which an unkilled monster ends the game; 1..2^TIMER_W-1.
REQ-005 timer_clk  in  1  game tick clock, rising edge.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 play  in  1  start request, level-sampled.
REQ-008 restart  in  1  return-to-home request, level-sampled.
REQ-009 kill  in  NUM_LANES  per-lane shot hit, sampled each tick.
REQ-010 rand_bits  in  NUM_LANES  per-lane spawn permission from the random source.
REQ-011 monster  out  NUM_LANES  registered; bit i = 1 while lane i is FULL.
REQ-012 gameover  out  1  registered; 1 while the global FSM is OVER.
REQ-013 active_cnt  out  clog2(NUM_LANES+1)  registered count of FULL lanes.
REQ-014 q_state  out  3  one-hot global state {OVER, PLAY, INIT}.

Function
REQ-015 The global FSM SHALL have states INIT, PLAY and OVER; any illegal encoding SHALL go to INIT on the next tick.
REQ-016 INIT SHALL hold all lanes EMPTY with age=0 and delay=0; it SHALL move to PLAY on a tick with play=1.
REQ-017 PLAY SHALL move to OVER on the tick any lane's age becomes GAMEOVER_LIMIT; restart SHALL be ignored in PLAY.
REQ-018 OVER SHALL freeze all lane states and counters; it SHALL move to INIT on a tick with restart=1; play SHALL be ignored in OVER.
REQ-019 In PLAY, an EMPTY lane SHALL increment delay each tick, saturating at SPAWN_DELAY.
REQ-020 An EMPTY lane with delay==SPAWN_DELAY and rand_bits[i]=1 SHALL become FULL on that tick, with age=0 and delay=0.
REQ-021 A FULL lane with kill[i]=1 SHALL become EMPTY on that tick, with age=0 and delay=0.
REQ-022 A FULL lane without kill SHALL increment age by 1 per tick.
REQ-023 kill[i] on an EMPTY lane SHALL be ignored.
REQ-024 On a tick where kill[i]=1 and age+1 would equal GAMEOVER_LIMIT, the kill SHALL win: the lane empties and no game over occurs.
REQ-025 Lanes SHALL be fully independent; simultaneous spawns and kills on multiple lanes SHALL all take effect on the same tick.
REQ-026 monster, gameover, active_cnt and q_state SHALL update on the same edge as the state change they reflect (one-tick latency from the sampled inputs).

Reset
REQ-027 Reset=1 SHALL immediately force INIT, with monster=0, gameover=0, active_cnt=0, all counters 0 and q_state=3'b001, regardless of timer_clk.
REQ-028 Reset asserted mid-game or during OVER SHALL discard all lane state; after release, play is required again before spawning resumes.

Configuration
REQ-029 With macro NEXYS_STARSHIP_SCORE_EN defined, an output score[15:0] SHALL exist, cleared in INIT and by Reset.
REQ-030 In PLAY, score SHALL increase each tick by the number of lanes killed per REQ-021, saturating at 16'hFFFF.
REQ-031 Without NEXYS_STARSHIP_SCORE_EN, the score port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-032 Reset, play=1, rand_bits=4'b0001 held -> lane 0 FULL at the 3rd tick after PLAY entry (SPAWN_DELAY=2); monster=4'b0001, active_cnt=1.
REQ-033 Lane 0 FULL, no kill -> gameover=1 and q_state=3'b100 on the 10th tick after spawn; monster frozen; restart=1 -> INIT, monster=0.
REQ-034 Lane 0 FULL at age 9, kill[0]=1 on the same tick -> lane empties, gameover stays 0, score+1 (macro on).
REQ-035 All 4 lanes FULL, kill=4'b1111 in one tick -> monster=0, active_cnt=0, score+4; score preloaded to 16'hFFFE saturates at 16'hFFFF.
REQ-036 Reset pulsed mid-PLAY with 2 lanes FULL and asynchronous to timer_clk -> outputs zero immediately; play=0 afterwards -> no spawn for 20 ticks.
